// File: rtl/ga_run_ctrl.sv
// ga_run_ctrl: multi-run sequencer for one GA core; keeps the best result over a job.
// Optional per-run watchdog: define GA_RUN_TIMEOUT_EN.
module ga_run_ctrl #(
   parameter int MAX_RUNS    = 8,
   parameter int CHROM_W     = 8,
   parameter int FIT_W       = 27,
   parameter int RESET_CYC   = 2,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [$clog2(MAX_RUNS+1)-1:0] num_runs,
   input  logic [31:0]                   base_seed,
   output logic                          core_reset,
   output logic [31:0]                   core_seed,
   input  logic                          core_finished,
   input  logic [CHROM_W-1:0]            core_best,
   input  logic [FIT_W-1:0]              core_best_fit,
   output logic                          busy,
   output logic                          done,
   output logic [$clog2(MAX_RUNS)-1:0]   run_idx,
   output logic [CHROM_W-1:0]            g_best,
   output logic [FIT_W-1:0]              g_best_fit,
   output logic [$clog2(MAX_RUNS)-1:0]   g_best_run,
   output logic                          timeout_err
);

   localparam int NW = $clog2(MAX_RUNS+1);
   localparam int CW = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;
   localparam logic [NW-1:0] MAXR = NW'(MAX_RUNS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RST  = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]    state;
   logic [CW-1:0] rst_cnt;
   logic [NW-1:0] runs_eff;
   logic [NW-1:0] runs_cl;
   logic          fin_q;
   logic          accept;
   logic          rise;
   logic          tmo;
   logic          end_run;
   logic          last_run;
   logic          take;
   logic [31:0]   seed_nxt;

   assign core_reset = (state != S_RUN);
   assign busy       = (state == S_RST) || (state == S_RUN);
   assign done       = (state == S_DONE);

   assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
   assign rise     = (state == S_RUN) && core_finished && !fin_q;
   assign end_run  = rise || tmo;
   assign last_run = (NW'(run_idx) == (runs_eff - NW'(1)));
   assign take     = rise && ((run_idx == '0) || (core_best_fit > g_best_fit));
   assign seed_nxt = {1'b0, core_seed[31:1]}
                   ^ (core_seed[0] ? 32'h8020_0003 : 32'h0);

   // Clamp the requested run count to 1..MAX_RUNS
   always_comb begin
      runs_cl = num_runs;
      if (num_runs == '0)
         runs_cl = NW'(1);
      else if (num_runs > MAXR)
         runs_cl = MAXR;
   end

   // Previous finished level; held high while the core is in reset so a stuck level never counts
   always_ff @(posedge clk) begin
      if (reset)
         fin_q <= 1'b1;
      else if (core_reset)
         fin_q <= 1'b1;
      else
         fin_q <= core_finished;
   end

`ifdef GA_RUN_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC+1);
   logic [TW-1:0] tcnt;

   assign tmo = (state == S_RUN) && !rise && (tcnt == TW'(TIMEOUT_CYC-1));

   // Per-run watchdog: zero outside RUN, counts RUN cycles
   always_ff @(posedge clk) begin
      if (reset)
         tcnt <= '0;
      else if (state != S_RUN)
         tcnt <= '0;
      else
         tcnt <= tcnt + TW'(1);
   end
`else
   assign tmo = 1'b0;
`endif

   // Run sequencing, seed stepping and best-of-job capture
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         rst_cnt     <= '0;
         runs_eff    <= '0;
         run_idx     <= '0;
         core_seed   <= '0;
         g_best      <= '0;
         g_best_fit  <= '0;
         g_best_run  <= '0;
         timeout_err <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  runs_eff    <= runs_cl;
                  core_seed   <= (base_seed == 32'h0) ? 32'h1 : base_seed;
                  run_idx     <= '0;
                  g_best      <= '0;
                  g_best_fit  <= '0;
                  g_best_run  <= '0;
                  timeout_err <= 1'b0;
                  rst_cnt     <= '0;
                  state       <= S_RST;
               end
            end
            S_RST: begin
               if (rst_cnt == CW'(RESET_CYC-1))
                  state <= S_RUN;
               else
                  rst_cnt <= rst_cnt + CW'(1);
            end
            S_RUN: begin
               if (take) begin
                  g_best     <= core_best;
                  g_best_fit <= core_best_fit;
                  g_best_run <= run_idx;
               end
               if (tmo)
                  timeout_err <= 1'b1;
               if (end_run) begin
                  if (last_run) begin
                     state <= S_DONE;
                  end else begin
                     run_idx   <= run_idx + 1'b1;
                     core_seed <= seed_nxt;
                     rst_cnt   <= '0;
                     state     <= S_RST;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ga_run_ctrl.sv
// tb_ga_run_ctrl: randomized jobs against a stub GA core, scoreboarded
// against a job-level reference model.
module tb_ga_run_ctrl;

   localparam int RESET_CYC = 2;
   localparam int TOUT      = 50;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  num_runs;
   logic [31:0] base_seed;
   logic        core_reset;
   logic [31:0] core_seed;
   logic        core_finished;
   logic [7:0]  core_best;
   logic [26:0] core_best_fit;
   logic        busy;
   logic        done;
   logic [2:0]  run_idx;
   logic [7:0]  g_best;
   logic [26:0] g_best_fit;
   logic [2:0]  g_best_run;
   logic        timeout_err;

   ga_run_ctrl #(.RESET_CYC(RESET_CYC), .TIMEOUT_CYC(TOUT)) dut (
      .clk(clk), .reset(reset), .start(start), .num_runs(num_runs),
      .base_seed(base_seed), .core_reset(core_reset), .core_seed(core_seed),
      .core_finished(core_finished), .core_best(core_best),
      .core_best_fit(core_best_fit), .busy(busy), .done(done),
      .run_idx(run_idx), .g_best(g_best), .g_best_fit(g_best_fit),
      .g_best_run(g_best_run), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // stub core: finishes k_tab cycles after its reset falls
   logic [7:0]  chr_tab [8];
   logic [26:0] fit_tab [8];
   int          k_tab   [8];
   bit          hang_tab[8];
   int          ccnt;

   always @(posedge clk) ccnt <= core_reset ? 0 : ccnt + 1;

   assign core_finished = !core_reset && !hang_tab[run_idx] && (ccnt >= k_tab[run_idx]);
   assign core_best     = chr_tab[run_idx];
   assign core_best_fit = fit_tab[run_idx];

   typedef struct { int idx; logic [31:0] seed; } run_t;
   typedef struct {
      logic [7:0] ch; logic [26:0] fit; int run; int last; bit tmo;
   } job_t;

   run_t run_q[$];
   job_t job_q[$];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [31:0] lfsr(input logic [31:0] s);
      logic [31:0] n;
      n = s / 2;
      if (s % 2 == 1) n = n ^ 32'h8020_0003;
      return n;
   endfunction

   // monitor: RUN entry checks seed/index, done rise checks the job result
   logic prev_cr = 1'b1;
   logic prev_dn = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         if (prev_cr && !core_reset) begin
            if (run_q.size() == 0) chk("unexpected_run", 1, 0);
            else begin
               run_t r;
               r = run_q.pop_front();
               chk("run_seed", core_seed, r.seed);
               chk("run_idx", run_idx, r.idx);
            end
         end
         if (done && !prev_dn) begin
            if (job_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               job_t j;
               j = job_q.pop_front();
               chk("g_best", g_best, j.ch);
               chk("g_best_fit", g_best_fit, j.fit);
               chk("g_best_run", g_best_run, j.run);
               chk("final_run_idx", run_idx, j.last);
               chk("timeout_err", timeout_err, j.tmo);
            end
         end
      end
      prev_cr = core_reset;
      prev_dn = done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_job(input int n, input logic [31:0] base);
      int runs;
      logic [31:0] seed;
      job_t j;
      runs = (n == 0) ? 1 : ((n > 8) ? 8 : n);
      seed = (base == 0) ? 32'h1 : base;
      j = '{ch: 0, fit: 0, run: 0, last: runs - 1, tmo: 0};
      for (int r = 0; r < runs; r++) begin
         run_q.push_back('{idx: r, seed: seed});
         if (hang_tab[r]) j.tmo = 1;
         else if (r == 0 || fit_tab[r] > j.fit) begin
            j.fit = fit_tab[r];
            j.ch  = chr_tab[r];
            j.run = r;
         end
         seed = lfsr(seed);
      end
      job_q.push_back(j);
   endtask

   task automatic rand_tables(input int fmax);
      for (int i = 0; i < 8; i++) begin
         chr_tab[i]  = 8'($urandom);
         fit_tab[i]  = 27'($urandom_range(0, fmax));
         k_tab[i]    = $urandom_range(1, 6);
         hang_tab[i] = 0;
      end
   endtask

   task automatic run_job(input int n, input logic [31:0] base, input bit noise);
      int c;
      model_job(n, base);
      num_runs  = 4'(n);
      base_seed = base;
      start     = 1'b1;
      tick();
      start = 1'b0;
      c = 0;
      while (core_reset && c < 20) begin
         tick();
         c++;
      end
      chk("start_latency", c + 1, 1 + RESET_CYC);
      c = 0;
      while (!done && c < 3000) begin
         tick();
         c++;
         if (noise && !done && ($urandom_range(0, 6) == 0)) begin
            start     = 1'b1;
            num_runs  = 4'($urandom);
            base_seed = $urandom;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk("job_done", done, 1);
      chk("busy_at_done", busy, 0);
      tick();
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; num_runs = '0; base_seed = '0;
      rand_tables(100);
      repeat (3) tick();
      reset = 1'b0;
      repeat (10) tick();
      chk("idle_core_reset", core_reset, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_seed", core_seed, 0);
      chk("idle_run_idx", run_idx, 0);
      chk("idle_g_best", g_best, 0);
      chk("idle_g_best_fit", g_best_fit, 0);
      chk("idle_g_best_run", g_best_run, 0);
      chk("idle_timeout", timeout_err, 0);

      fit_tab[0] = 100; fit_tab[1] = 300; fit_tab[2] = 300;
      run_job(3, 32'h895C_80A7, 0);

      rand_tables(1000);
      run_job(0, 32'h0, 0);

      rand_tables(20);
      run_job(12, $urandom, 1);

      for (int t = 0; t < 8; t++) begin
         rand_tables((t % 2 == 0) ? 3 : 27'h7FF_FFFF);
         run_job($urandom_range(0, 10), ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, t % 2);
      end

      // abort in run 1
      rand_tables(500);
      model_job(3, 32'hDEAD_BEEF);
      num_runs = 4'd3; base_seed = 32'hDEAD_BEEF; start = 1'b1;
      tick();
      start = 1'b0;
      begin
         int c;
         c = 0;
         while (!(run_idx == 3'd1 && !core_reset) && c < 200) begin
            tick();
            c++;
         end
         chk("reach_run1", c < 200, 1);
      end
      reset = 1'b1;
      tick();
      chk("abort_core_reset", core_reset, 1);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_g_best_fit", g_best_fit, 0);
      chk("abort_run_idx", run_idx, 0);
      chk("abort_seed", core_seed, 0);
      reset = 1'b0;
      run_q.delete();
      job_q.delete();
      tick();
      rand_tables(1000);
      run_job(2, 32'h1234_5678, 0);

`ifdef GA_RUN_TIMEOUT_EN
      rand_tables(1000);
      hang_tab[0] = 1;
      fit_tab[1]  = 7;
      run_job(2, 32'hCAFE_0001, 0);
      hang_tab[0] = 0;
`endif

      repeat (3) tick();
      chk("run_q_empty", run_q.size(), 0);
      chk("job_q_empty", job_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
